// File: rtl/lab0_vector_seq.sv
// Clocked sweep of all eight {a,b,c} vectors into lab0, checking y/z against parameterised truth tables.
// Define LAB0_VSEQ_RESP_EN to build the 16-bit response capture register; otherwise resp reads zero.
module lab0_vector_seq #(
  parameter int          HOLD_CYCLES = 1,
  parameter logic [7:0]  EXP_Y       = 8'hE8,
  parameter logic [7:0]  EXP_Z       = 8'h96
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        a,
  output logic        b,
  output logic        c,
  input  logic        y,
  input  logic        z,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [3:0]  err_count,
  output logic [2:0]  fail_vec,
  output logic [15:0] resp
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam logic [3:0] LAST_HOLD = 4'(HOLD_CYCLES - 1);

  state_t     state;
  state_t     nextState;
  logic [2:0] idx;
  logic [3:0] holdCnt;
  logic [3:0] errCount;
  logic [2:0] failVec;
  logic       sampleEdge;
  logic       launch;
  logic       mismatch;

  assign sampleEdge = (state == DRIVE) && (holdCnt == LAST_HOLD);
  assign launch     = (state != DRIVE) && start;
  assign mismatch   = (y != EXP_Y[idx]) || (z != EXP_Z[idx]);

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = DRIVE;
      DRIVE:   if (sampleEdge && idx == 3'd7) nextState = DONE;
      DONE:    if (start) nextState = DRIVE;
      default: nextState = IDLE;
    endcase
  end

  // Everything visible is decoded from registered state, so no input reaches an output combinationally.
  always_comb begin
    busy      = (state == DRIVE);
    done      = (state == DONE);
    pass      = (state == DONE) && (errCount == 4'd0);
    {a, b, c} = (state == DRIVE) ? idx : 3'd0;
  end

  always_ff @(posedge clk) begin
    if (reset || launch) begin
      idx      <= 3'd0;
      holdCnt  <= 4'd0;
      errCount <= 4'd0;
      failVec  <= 3'd0;
    end else if (state == DRIVE) begin
      if (sampleEdge) begin
        idx     <= idx + 3'd1;
        holdCnt <= 4'd0;
        if (mismatch) begin
          errCount <= errCount + 4'd1;
          if (errCount == 4'd0)
            failVec <= idx;
        end
      end else begin
        holdCnt <= holdCnt + 4'd1;
      end
    end
  end

  assign err_count = errCount;
  assign fail_vec  = failVec;

`ifdef LAB0_VSEQ_RESP_EN
  logic [15:0] respReg;

  // Capture every sampled pair regardless of match, so a failing lab0 can be diagnosed from one sweep.
  always_ff @(posedge clk) begin
    if (reset || launch)
      respReg <= 16'h0000;
    else if (sampleEdge) begin
      respReg[{idx, 1'b1}] <= y;
      respReg[{idx, 1'b0}] <= z;
    end
  end

  assign resp = respReg;
`else
  assign resp = 16'h0000;
`endif

endmodule

// File: tb/tb_lab0_vector_seq.sv
// Directed bench for lab0_vector_seq: one instance at HOLD_CYCLES=1 and one at HOLD_CYCLES=3,
// each fed by a behavioural lab0 (majority / odd parity) with an optional y stuck-at-0 fault.
module tb_lab0_vector_seq;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start1 = 1'b0;
  logic start3 = 1'b0;
  logic stuckY = 1'b0;

  logic a1, b1, c1, y1, z1, busy1, done1, pass1;
  logic [3:0]  err1;
  logic [2:0]  fail1;
  logic [15:0] resp1;

  logic a3, b3, c3, y3, z3, busy3, done3, pass3;
  logic [3:0]  err3;
  logic [2:0]  fail3;
  logic [15:0] resp3;

  int testCount = 0;
  int failCount = 0;

`ifdef LAB0_VSEQ_RESP_EN
  localparam logic [15:0] RESP_OK    = 16'hE994;
  localparam logic [15:0] RESP_STUCK = 16'h4114;
`else
  localparam logic [15:0] RESP_OK    = 16'h0000;
  localparam logic [15:0] RESP_STUCK = 16'h0000;
`endif

  always #5 clk = ~clk;

  assign y1 = stuckY ? 1'b0 : ((a1 & b1) | (a1 & c1) | (b1 & c1));
  assign z1 = a1 ^ b1 ^ c1;
  assign y3 = (a3 & b3) | (a3 & c3) | (b3 & c3);
  assign z3 = a3 ^ b3 ^ c3;

  lab0_vector_seq dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .a(a1), .b(b1), .c(c1), .y(y1), .z(z1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_vec(fail1), .resp(resp1)
  );

  lab0_vector_seq #(.HOLD_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3),
    .a(a3), .b(b3), .c(c3), .y(y3), .z(z3),
    .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .fail_vec(fail3), .resp(resp3)
  );

  // Set inputs, then advance through one rising edge and settle 1 time unit past it.
  task automatic applyStimulus(input logic rst, input logic s1, input logic s3);
    reset  = rst;
    start1 = s1;
    start3 = s3;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkReset1(input string tag);
    checkOutput({tag, "_abc"},  16'({a1, b1, c1}), 16'h0);
    checkOutput({tag, "_busy"}, 16'(busy1), 16'h0);
    checkOutput({tag, "_done"}, 16'(done1), 16'h0);
    checkOutput({tag, "_pass"}, 16'(pass1), 16'h0);
    checkOutput({tag, "_err"},  16'(err1),  16'h0);
    checkOutput({tag, "_fail"}, 16'(fail1), 16'h0);
    checkOutput({tag, "_resp"}, resp1, 16'h0000);
  endtask

  task automatic checkResults1(input string tag, input logic p, input logic [3:0] e,
                               input logic [2:0] f, input logic [15:0] r);
    checkOutput({tag, "_done"}, 16'(done1), 16'h1);
    checkOutput({tag, "_busy"}, 16'(busy1), 16'h0);
    checkOutput({tag, "_pass"}, 16'(pass1), 16'(p));
    checkOutput({tag, "_err"},  16'(err1),  16'(e));
    checkOutput({tag, "_fail"}, 16'(fail1), 16'(f));
    checkOutput({tag, "_resp"}, resp1, r);
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkReset1("reset");
    checkOutput("reset_busy3", 16'(busy3), 16'h0);

    // Correct lab0, single sweep: vector i visible after E0+i, done exactly at E0+8.
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("s1_busy_e0", 16'(busy1), 16'h1);
    checkOutput("s1_abc_e0", 16'({a1, b1, c1}), 16'h0);
    for (int i = 1; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("s1_abc_%0d", i), 16'({a1, b1, c1}), 16'(i));
      checkOutput($sformatf("s1_done_%0d", i), 16'(done1), 16'h0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkResults1("s1_end", 1'b1, 4'd0, 3'd0, RESP_OK);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkResults1("s1_hold", 1'b1, 4'd0, 3'd0, RESP_OK);

    // y stuck at 0: vectors 3,5,6,7 miss, first is 3.
    stuckY = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkResults1("stuck", 1'b0, 4'd4, 3'd3, RESP_STUCK);

    // Restart from a failing DONE with a good model: results clear on the start edge.
    stuckY = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("rerun_err_e0", 16'(err1), 16'h0);
    checkOutput("rerun_fail_e0", 16'(fail1), 16'h0);
    checkOutput("rerun_pass_e0", 16'(pass1), 16'h0);
    checkOutput("rerun_resp_e0", resp1, 16'h0000);
    for (int i = 1; i <= 8; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkResults1("rerun", 1'b1, 4'd0, 3'd0, RESP_OK);

    // Reset while vector 4 is driven, then a clean sweep.
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("mid_abc4", 16'({a1, b1, c1}), 16'h4);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkReset1("midreset");
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("midreset_idle", 16'(busy1), 16'h0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkResults1("after_reset", 1'b1, 4'd0, 3'd0, RESP_OK);

    // start held high: back-to-back sweeps with a single DONE cycle showing the finished sweep.
    stuckY = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkResults1("b2b_done", 1'b0, 4'd4, 3'd3, RESP_STUCK);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("b2b_done_off", 16'(done1), 16'h0);
    checkOutput("b2b_busy_on", 16'(busy1), 16'h1);
    checkOutput("b2b_err_clr", 16'(err1), 16'h0);
    for (int i = 1; i <= 8; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("b2b_done2", 16'(done1), 16'h1);
    checkOutput("b2b_err2", 16'(err1), 16'h4);
    stuckY = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);

    // HOLD_CYCLES=3: each vector held three cycles, start mid-sweep ignored, done at E0+24.
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("h3_busy_e0", 16'(busy3), 16'h1);
    checkOutput("h3_abc_0", 16'({a3, b3, c3}), 16'h0);
    for (int t = 1; t < 24; t++) begin
      applyStimulus(1'b0, 1'b0, (t == 5 || t == 6));
      checkOutput($sformatf("h3_abc_%0d", t), 16'({a3, b3, c3}), 16'(t / 3));
      checkOutput($sformatf("h3_done_%0d", t), 16'(done3), 16'h0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("h3_done_24", 16'(done3), 16'h1);
    checkOutput("h3_pass", 16'(pass3), 16'h1);
    checkOutput("h3_err", 16'(err3), 16'h0);
    checkOutput("h3_resp", resp3, RESP_OK);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
